// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: widths, trap code and FSM encoding.
package ysyx_041461_pipe_ctrl_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned TRAP_W = 4;
    localparam int unsigned PERF_W = 64;

    localparam logic [TRAP_W-1:0] TRAP_NOP = 4'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/ysyx_041461_pipe_ctrl_stage_vld.sv
// One stage valid bit: load from upstream on advance, bubble when only downstream moves.
module ysyx_041461_stage_vld (
    input  logic clk,
    input  logic rst_n,
    input  logic up_adv,
    input  logic dn_adv,
    input  logic up_valid,
    input  logic kill,
    output logic valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (up_adv) begin
            valid <= up_valid & !kill;
        end else if (dn_adv) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline sequencer: stage enables, valid bits, branch and trap redirects.
// Define YSYX_041461_PERF_EN to add the perf_cycle/perf_stall/perf_trap counters.
module ysyx_041461_pipe_ctrl
    import ysyx_041461_pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_ready,
    input  logic              mem_busy,
    input  logic              cd_id_conflict,
    input  logic              cd_exe_conflict,
    input  logic              cd_mem_conflict,
    input  logic              cd_if_trap,
    input  logic              cd_if2_trap,
    input  logic              cd_id_trap,
    input  logic              cd_exe_trap,
    input  logic              cd_mem_trap,
    input  logic [TRAP_W-1:0] wb_trap,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              id_redirect,
    input  logic [XLEN-1:0]   id_redirect_pc,
    input  logic              redirect_ready,
    output logic              if_en,
    output logic              if2_en,
    output logic              id_en,
    output logic              exe_en,
    output logic              mem_en,
    output logic              if2_valid,
    output logic              id_valid,
    output logic              exe_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              trap_busy
`ifdef YSYX_041461_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycle,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_trap
`endif
);

    state_t          state;
    logic [XLEN-1:0] target;
    logic            run;
    logic            id_stall_br;
    logic            trap_take;
    logic            branch_kill;

    // A WB trap outranks a same-cycle branch: ID is flushed, so its redirect is dropped.
    always_comb begin
        run            = (state == ST_RUN);
        mem_en         = run & !mem_busy & !cd_mem_conflict;
        exe_en         = mem_en & !cd_exe_conflict;
        id_stall_br    = id_valid & id_redirect & !redirect_ready;
        id_en          = exe_en & !cd_id_conflict & !id_stall_br;
        if2_en         = id_en;
        if_en          = if2_en;
        trap_take      = run & wb_valid & (wb_trap != TRAP_NOP);
        branch_kill    = run & id_valid & id_redirect & id_en & !trap_take;
        redirect_valid = branch_kill | (state == ST_REDIRECT);
        redirect_pc    = (state == ST_REDIRECT) ? target : id_redirect_pc;
        trap_busy      = !run;
    end

    // A trap flush is folded in as a forced advance with kill, emptying every stage.
    ysyx_041461_stage_vld u_vld_if2 (
        .clk(clk), .rst_n(rst_n),
        .up_adv(if_en | trap_take), .dn_adv(if2_en),
        .up_valid(if_ready), .kill(cd_if_trap | branch_kill | trap_take),
        .valid(if2_valid)
    );

    ysyx_041461_stage_vld u_vld_id (
        .clk(clk), .rst_n(rst_n),
        .up_adv(if2_en | trap_take), .dn_adv(id_en),
        .up_valid(if2_valid), .kill(cd_if2_trap | branch_kill | trap_take),
        .valid(id_valid)
    );

    ysyx_041461_stage_vld u_vld_exe (
        .clk(clk), .rst_n(rst_n),
        .up_adv(id_en | trap_take), .dn_adv(exe_en),
        .up_valid(id_valid), .kill(cd_id_trap | trap_take),
        .valid(exe_valid)
    );

    ysyx_041461_stage_vld u_vld_mem (
        .clk(clk), .rst_n(rst_n),
        .up_adv(exe_en | trap_take), .dn_adv(mem_en),
        .up_valid(exe_valid), .kill(cd_exe_trap | trap_take),
        .valid(mem_valid)
    );

    // WB retires every cycle, so it bubbles whenever MEM does not advance.
    ysyx_041461_stage_vld u_vld_wb (
        .clk(clk), .rst_n(rst_n),
        .up_adv(mem_en | trap_take), .dn_adv(1'b1),
        .up_valid(mem_valid), .kill(cd_mem_trap | trap_take),
        .valid(wb_valid)
    );

    // Trap redirect sequencing: wait out any bus access, then hold the redirect until IF takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            target <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (trap_take) begin
                        target <= trap_pc;
                        state  <= mem_busy ? ST_WAIT_MEM : ST_REDIRECT;
                    end
                end
                ST_WAIT_MEM: begin
                    if (!mem_busy) state <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef YSYX_041461_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycle <= '0;
            perf_stall <= '0;
            perf_trap  <= '0;
        end else begin
            perf_cycle <= perf_cycle + PERF_W'(1);
            if (run & id_valid & !id_en) perf_stall <= perf_stall + PERF_W'(1);
            if (trap_take)               perf_trap  <= perf_trap + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Scenario bench for ysyx_041461_pipe_ctrl: per-cycle expectations queued, then compared mid-cycle.
module tb_ysyx_041461_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_ready, mem_busy;
    logic        cd_id_conflict, cd_exe_conflict, cd_mem_conflict;
    logic        cd_if_trap, cd_if2_trap, cd_id_trap, cd_exe_trap, cd_mem_trap;
    logic [3:0]  wb_trap;
    logic [63:0] trap_pc, id_redirect_pc;
    logic        id_redirect, redirect_ready;
    logic        if_en, if2_en, id_en, exe_en, mem_en;
    logic        if2_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic        redirect_valid, trap_busy;
    logic [63:0] redirect_pc;
`ifdef YSYX_041461_PERF_EN
    logic [63:0] perf_cycle, perf_stall, perf_trap;
`endif

    ysyx_041461_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_ready(if_ready), .mem_busy(mem_busy),
        .cd_id_conflict(cd_id_conflict), .cd_exe_conflict(cd_exe_conflict),
        .cd_mem_conflict(cd_mem_conflict),
        .cd_if_trap(cd_if_trap), .cd_if2_trap(cd_if2_trap), .cd_id_trap(cd_id_trap),
        .cd_exe_trap(cd_exe_trap), .cd_mem_trap(cd_mem_trap),
        .wb_trap(wb_trap), .trap_pc(trap_pc),
        .id_redirect(id_redirect), .id_redirect_pc(id_redirect_pc),
        .redirect_ready(redirect_ready),
        .if_en(if_en), .if2_en(if2_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en),
        .if2_valid(if2_valid), .id_valid(id_valid), .exe_valid(exe_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_busy(trap_busy)
`ifdef YSYX_041461_PERF_EN
        ,
        .perf_cycle(perf_cycle), .perf_stall(perf_stall), .perf_trap(perf_trap)
`endif
    );

    // ctl = {if_en,if2_en,id_en,exe_en,mem_en, if2,id,exe,mem,wb valid, redirect_valid, trap_busy}
    typedef struct {
        logic [11:0] ctl;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] obs_ctl();
        return {if_en, if2_en, id_en, exe_en, mem_en,
                if2_valid, id_valid, exe_valid, mem_valid, wb_valid,
                redirect_valid, trap_busy};
    endfunction

    task automatic set_idle();
        if_ready = 1'b1; mem_busy = 1'b0;
        cd_id_conflict = 1'b0; cd_exe_conflict = 1'b0; cd_mem_conflict = 1'b0;
        cd_if_trap = 1'b0; cd_if2_trap = 1'b0; cd_id_trap = 1'b0;
        cd_exe_trap = 1'b0; cd_mem_trap = 1'b0;
        wb_trap = 4'd0; trap_pc = 64'h0;
        id_redirect = 1'b0; id_redirect_pc = 64'h0; redirect_ready = 1'b1;
    endtask

    task automatic run_idle(input int n);
        set_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] t [2];
        t = '{12'b00000_00000_0_0, 12'b11111_00000_0_0};
        rst_n = 1'b0;
        set_idle();
        if_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mem_busy = (c == 0);
            sb.push_back('{t[c], 64'h0});
            #2;
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl) begin
                n_err++;
                $display("FAIL reset[%0d]: got ctl=%b, want ctl=%b", c, obs_ctl(), e.ctl);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        logic [11:0] t [6];
        t = '{12'b11111_00000_0_0, 12'b11111_10000_0_0, 12'b11111_11000_0_0,
              12'b11111_11100_0_0, 12'b11111_11110_0_0, 12'b11111_11111_0_0};
        for (int c = 0; c < 6; c++) begin
            set_idle();
            sb.push_back('{t[c], 64'h0});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl) begin
                n_err++;
                $display("FAIL fill[%0d]: got ctl=%b, want ctl=%b", c, obs_ctl(), e.ctl);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hazard_stall();
        logic [11:0] t [5];
        t = '{12'b00001_11111_0_0, 12'b00001_11101_0_0, 12'b11111_11100_0_0,
              12'b11111_11110_0_0, 12'b11111_11111_0_0};
        run_idle(6);
        for (int c = 0; c < 5; c++) begin
            set_idle();
            cd_exe_conflict = (c < 2);
            sb.push_back('{t[c], 64'h0});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl) begin
                n_err++;
                $display("FAIL hazard_stall[%0d]: got ctl=%b, want ctl=%b", c, obs_ctl(), e.ctl);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        logic [11:0] t [7];
        t = '{12'b11111_11111_1_0, 12'b11111_00111_0_0, 12'b11111_10011_0_0,
              12'b11111_11001_0_0, 12'b11111_11100_0_0, 12'b11111_11110_0_0,
              12'b11111_11111_0_0};
        run_idle(6);
        for (int c = 0; c < 7; c++) begin
            set_idle();
            id_redirect    = (c == 0);
            id_redirect_pc = 64'h0000_0000_8000_0100;
            sb.push_back('{t[c], 64'h0000_0000_8000_0100});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl || (e.ctl[1] && redirect_pc !== e.pc)) begin
                n_err++;
                $display("FAIL branch[%0d]: got ctl=%b pc=%h, want ctl=%b pc=%h",
                         c, obs_ctl(), redirect_pc, e.ctl, e.pc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_hold();
        logic [11:0] t [5];
        t = '{12'b00011_11111_0_0, 12'b00011_11011_0_0, 12'b00011_11001_0_0,
              12'b11111_11000_1_0, 12'b11111_00100_0_0};
        run_idle(6);
        for (int c = 0; c < 5; c++) begin
            set_idle();
            id_redirect    = (c < 4);
            redirect_ready = (c >= 3);
            id_redirect_pc = 64'h0000_0000_8000_0200;
            sb.push_back('{t[c], 64'h0000_0000_8000_0200});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl || (e.ctl[1] && redirect_pc !== e.pc)) begin
                n_err++;
                $display("FAIL branch_hold[%0d]: got ctl=%b pc=%h, want ctl=%b pc=%h",
                         c, obs_ctl(), redirect_pc, e.ctl, e.pc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Trap with idle MEM; a same-cycle ID branch must lose to the trap.
    task automatic test_trap_idle();
        logic [11:0] t [6];
        t = '{12'b11111_11111_0_0, 12'b00000_00000_1_1, 12'b00000_00000_1_1,
              12'b00000_00000_1_1, 12'b11111_00000_0_0, 12'b11111_10000_0_0};
        run_idle(6);
        for (int c = 0; c < 6; c++) begin
            set_idle();
            if (c == 0) begin
                wb_trap        = 4'd3;
                trap_pc        = 64'h0000_0000_8000_0000;
                id_redirect    = 1'b1;
                id_redirect_pc = 64'h0000_0000_8000_0100;
            end else begin
                trap_pc = 64'h0000_0000_1234_5678;
            end
            redirect_ready = (c == 0 || c >= 3);
            sb.push_back('{t[c], 64'h0000_0000_8000_0000});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl || (e.ctl[1] && redirect_pc !== e.pc)) begin
                n_err++;
                $display("FAIL trap_idle[%0d]: got ctl=%b pc=%h, want ctl=%b pc=%h",
                         c, obs_ctl(), redirect_pc, e.ctl, e.pc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_trap_wait_mem();
        logic [11:0] t [8];
        t = '{12'b00000_11111_0_0, 12'b00000_00000_0_1, 12'b00000_00000_0_1,
              12'b00000_00000_0_1, 12'b00000_00000_0_1, 12'b00000_00000_0_1,
              12'b00000_00000_1_1, 12'b11111_00000_0_0};
        run_idle(6);
        for (int c = 0; c < 8; c++) begin
            set_idle();
            if (c == 0) begin
                wb_trap = 4'd5;
                trap_pc = 64'h0000_0000_8000_0040;
            end
            mem_busy = (c <= 4);
            sb.push_back('{t[c], 64'h0000_0000_8000_0040});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl || (e.ctl[1] && redirect_pc !== e.pc)) begin
                n_err++;
                $display("FAIL trap_wait_mem[%0d]: got ctl=%b pc=%h, want ctl=%b pc=%h",
                         c, obs_ctl(), redirect_pc, e.ctl, e.pc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset pulsed while holding the redirect must take effect without a clock edge.
    task automatic test_reset_mid_flush();
        logic [11:0] t [3];
        t = '{12'b11111_11111_0_0, 12'b00000_00000_1_1, 12'b11111_00000_0_0};
        run_idle(6);
        for (int c = 0; c < 3; c++) begin
            set_idle();
            if (c == 0) begin
                wb_trap = 4'd2;
                trap_pc = 64'h0000_0000_8000_0080;
            end
            redirect_ready = 1'b0;
            if (c == 2) begin
                #1 rst_n = 1'b0;
            end
            sb.push_back('{t[c], 64'h0000_0000_8000_0080});
            if (c == 2) #1;
            else @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs_ctl() !== e.ctl || (e.ctl[1] && redirect_pc !== e.pc)) begin
                n_err++;
                $display("FAIL reset_mid_flush[%0d]: got ctl=%b pc=%h, want ctl=%b pc=%h",
                         c, obs_ctl(), redirect_pc, e.ctl, e.pc);
            end
            if (c == 2) #1 rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hazard_stall();
        test_branch();
        test_branch_hold();
        test_trap_idle();
        test_trap_wait_mem();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
